dds_param_loader: RTL
=====================

// Module: dds_param_loader
// PURPOSE
//  Consumes decoded UART command frames (recv_done + rev_data0..10) and turns
//  them into DDS control registers (tuning word, phase, amplitude, waveform, enable).
//  Updates are staged in shadow registers and committed only on a DDS-safe strobe
//  (dds_sync, e.g. phase-accumulator wrap), so the NCO never sees a torn update.
//  Sits directly downstream of the multi-byte UART receiver, upstream of the DDS core.
// PARAMETERS
//  FTW_RST      32'h0000_0000  ftw value after reset
//  AMP_RST      12'hFFF        amp value after reset
//  SYNC_TIMEOUT 1_000_000      max cycles in WAIT_SYNC before a forced commit (>=2)
//  SYNC_EN      1              0: dds_sync ignored; every commit happens on the first WAIT_SYNC cycle
// PORTS
//  sys_clk      in   1   system clock
//  sys_rst_n    in   1   synchronous reset, ACTIVE-HIGH (1 = reset)
//  recv_done    in   1   1-cycle pulse: rev_data0..10 hold a valid frame
//  rev_data0..10 in  8   frame bytes: 0=cmd, 1..4=FTW MSB first, 5..6=phase MSB first,
//                        7[3:0],8=amp[11:0], 9[2:0]=wave_sel, 10[0]=dds_en, 10[1]=phase_rst request
//  dds_sync     in   1   commit-safe strobe from the DDS core
//  ftw          out  32  active frequency tuning word
//  phase_off    out  16  active phase offset
//  amp          out  12  active amplitude
//  wave_sel     out  3   active waveform select
//  dds_en       out  1   DDS output enable
//  phase_rst    out  1   1-cycle pulse during APPLY if the committed request has phase_rst set
//  param_upd    out  1   1-cycle pulse; new active values are visible in the same cycle
//  sync_tmo     out  1   1-cycle pulse with param_upd when the commit was forced by timeout
//  busy         out  1   high in WAIT_SYNC and APPLY
//  cmd_err      out  1   1-cycle pulse on an unknown command
//  err_cnt      out  8   saturating count of unknown commands
//  ovr_cnt      out  8   saturating count of frames merged while a commit was pending
// BEHAVIOUR
//  Reset: ftw=FTW_RST, amp=AMP_RST; all other outputs, shadow registers, mask, counters = 0; state=IDLE.
//   Reset overrides everything in the same cycle and discards a pending commit.
//  Commands (rev_data0) set bits in the 5-bit shadow mask {en,wave,amp,phase,ftw}:
//   01 = all fields + phase_rst flag; 02 = ftw; 03 = phase_off; 04 = amp; 05 = dds_en only.
//   Any other value: no shadow/state change; cmd_err pulses at T+1; err_cnt++ (saturates at 255).
//  Latch on a valid recv_done: masked fields are written to shadow and mask |= new bits.
//   A newer frame overwrites the same field (last write wins).
//  FSM:
//   IDLE      valid recv_done -> latch, go to WAIT_SYNC (tmo counter = 0).
//   WAIT_SYNC dds_sync=1 (or SYNC_EN=0) -> APPLY.
//             Counter reaches SYNC_TIMEOUT-1 -> APPLY with sync_tmo.
//             Valid recv_done -> latch (merge), ovr_cnt++, stay in WAIT_SYNC, counter not reset.
//             recv_done and dds_sync in the same cycle: recv_done wins (merge),
//             sync is ignored, commit waits for the next sync.
//   APPLY     (1 cycle) masked fields are copied to the active outputs on entry edge;
//             param_upd=1; phase_rst=1 if requested; mask and phase_rst flag cleared.
//             Valid recv_done -> latch into the now-empty shadow, go to WAIT_SYNC (no ovr).
//             Otherwise -> IDLE.
//  Latency: recv_done at T, dds_sync at T+1 -> new values and param_upd at T+2 (minimum).
//   With SYNC_EN=0 the same T+2 applies.
//  Unmasked active fields hold their value. Invalid commands in WAIT_SYNC do not alter the pending commit.
// TESTING
//  Reset -> ftw=0, amp=FFF, dds_en=0, all pulses 0, busy=0.
//  cmd01 FTW=12345678 ph=0400 amp=0800 wave=2 flags=03, sync at T+5
//   -> outputs update at T+6; param_upd=1 and phase_rst=1 for 1 cycle; busy drops at T+7.
//  cmd02 FTW=AABBCCDD, then cmd04 amp=0123 before sync
//   -> single commit updates both fields; phase_off unchanged; ovr_cnt=1.
//  cmd=7F -> cmd_err pulse at T+1, err_cnt=1, busy stays 0, outputs unchanged.
//   256 more bad commands -> err_cnt=255.
//  SYNC_TIMEOUT=16, no dds_sync -> commit 16 cycles after entering WAIT_SYNC with sync_tmo=1.
//  recv_done coincident with dds_sync in WAIT_SYNC -> no commit that cycle; commit on the next sync.
//   Assert sys_rst_n mid-WAIT_SYNC -> no param_upd; state returns to IDLE.

Source files
------------

// File: rtl/dds_param_loader.sv
// DDS parameter loader: stages decoded UART frames in shadow registers
// and commits them to the NCO controls only on a DDS-safe strobe.
module dds_param_loader #(
  parameter logic [31:0] FTW_RST      = 32'h0000_0000,
  parameter logic [11:0] AMP_RST      = 12'hFFF,
  parameter int          SYNC_TIMEOUT = 1_000_000,
  parameter int          SYNC_EN      = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        recv_done,
  input  logic [7:0]  rev_data0,
  input  logic [7:0]  rev_data1,
  input  logic [7:0]  rev_data2,
  input  logic [7:0]  rev_data3,
  input  logic [7:0]  rev_data4,
  input  logic [7:0]  rev_data5,
  input  logic [7:0]  rev_data6,
  input  logic [7:0]  rev_data7,
  input  logic [7:0]  rev_data8,
  input  logic [7:0]  rev_data9,
  input  logic [7:0]  rev_data10,
  input  logic        dds_sync,
  output logic [31:0] ftw,
  output logic [15:0] phase_off,
  output logic [11:0] amp,
  output logic [2:0]  wave_sel,
  output logic        dds_en,
  output logic        phase_rst,
  output logic        param_upd,
  output logic        sync_tmo,
  output logic        busy,
  output logic        cmd_err,
  output logic [7:0]  err_cnt,
  output logic [7:0]  ovr_cnt
);

  localparam int CW = $clog2(SYNC_TIMEOUT);
  localparam logic [CW-1:0] TMO_LIM = CW'(SYNC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    APPLY
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0] tmo_cnt;
  logic [4:0]    mask;
  logic [4:0]    new_mask;
  logic [31:0]   sh_ftw;
  logic [15:0]   sh_phase;
  logic [11:0]   sh_amp;
  logic [2:0]    sh_wave;
  logic          sh_en;
  logic          sh_prst;
  logic          prst_q;
  logic          tmo_q;
  logic          cmd_ok;
  logic          commit;
  logic          tmo_hit;
  logic          sync_ok;
  logic          unused;

  assign unused = ^{rev_data7[7:4], rev_data9[7:3], rev_data10[7:2]};
  assign sync_ok = dds_sync || (SYNC_EN == 0);

  // mask bits: {en, wave, amp, phase, ftw}
  always_comb begin
    new_mask = 5'b0;
    case (rev_data0)
      8'h01:   new_mask = 5'b11111;
      8'h02:   new_mask = 5'b00001;
      8'h03:   new_mask = 5'b00010;
      8'h04:   new_mask = 5'b00100;
      8'h05:   new_mask = 5'b10000;
      default: new_mask = 5'b0;
    endcase
    cmd_ok = recv_done && (new_mask != 5'b0);
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    tmo_hit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_ok) state_nx = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        // A new frame always wins over the commit strobe
        if (cmd_ok) begin
          state_nx = WAIT_SYNC;
        end else if (sync_ok) begin
          state_nx = APPLY;
          commit   = 1'b1;
        end else if (tmo_cnt == TMO_LIM) begin
          state_nx = APPLY;
          commit   = 1'b1;
          tmo_hit  = 1'b1;
        end
      end
      APPLY: begin
        state_nx = cmd_ok ? WAIT_SYNC : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) state <= IDLE;
    else           state <= state_nx;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_n) begin
      tmo_cnt   <= '0;
      mask      <= '0;
      sh_ftw    <= '0;
      sh_phase  <= '0;
      sh_amp    <= '0;
      sh_wave   <= '0;
      sh_en     <= 1'b0;
      sh_prst   <= 1'b0;
      prst_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ftw       <= FTW_RST;
      phase_off <= '0;
      amp       <= AMP_RST;
      wave_sel  <= '0;
      dds_en    <= 1'b0;
      cmd_err   <= 1'b0;
      err_cnt   <= '0;
      ovr_cnt   <= '0;
    end else begin
      cmd_err <= recv_done && !cmd_ok;
      if (recv_done && !cmd_ok && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;

      if (state != WAIT_SYNC)
        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LIM)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (cmd_ok) begin
        mask <= mask | new_mask;
        if (new_mask[0]) sh_ftw <= {rev_data1, rev_data2, rev_data3, rev_data4};
        if (new_mask[1]) sh_phase <= {rev_data5, rev_data6};
        if (new_mask[2]) sh_amp <= {rev_data7[3:0], rev_data8};
        if (new_mask[3]) sh_wave <= rev_data9[2:0];
        if (new_mask[4]) sh_en <= rev_data10[0];
        if (new_mask == 5'b11111) sh_prst <= rev_data10[1];
        if (state == WAIT_SYNC && ovr_cnt != 8'hFF)
          ovr_cnt <= ovr_cnt + 8'd1;
      end

      prst_q <= 1'b0;
      tmo_q  <= 1'b0;
      if (commit) begin
        if (mask[0]) ftw       <= sh_ftw;
        if (mask[1]) phase_off <= sh_phase;
        if (mask[2]) amp       <= sh_amp;
        if (mask[3]) wave_sel  <= sh_wave;
        if (mask[4]) dds_en    <= sh_en;
        prst_q  <= sh_prst;
        tmo_q   <= tmo_hit;
        mask    <= '0;
        sh_prst <= 1'b0;
      end
    end
  end

  assign param_upd = (state == APPLY);
  assign busy      = (state == WAIT_SYNC) || (state == APPLY);
  assign phase_rst = param_upd && prst_q;
  assign sync_tmo  = param_upd && tmo_q;

endmodule
